// File: rtl/mem_access.sv
// Load/store access controller: alignment check, lane steering and a req/ack
// memory handshake with timeout, returning the raw word for mem_load.
module mem_access #(
    parameter int XLEN           = 32,
    parameter int MEM_TYPE_LEN   = 3,
    parameter int TIMEOUT_CYCLES = 255,
    // Access-type codes; defaults match the shared constants header encoding.
    parameter logic [MEM_TYPE_LEN-1:0] MEM_B  = MEM_TYPE_LEN'(0),
    parameter logic [MEM_TYPE_LEN-1:0] MEM_H  = MEM_TYPE_LEN'(1),
    parameter logic [MEM_TYPE_LEN-1:0] MEM_W  = MEM_TYPE_LEN'(2),
    parameter logic [MEM_TYPE_LEN-1:0] MEM_BU = MEM_TYPE_LEN'(4),
    parameter logic [MEM_TYPE_LEN-1:0] MEM_HU = MEM_TYPE_LEN'(5)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [MEM_TYPE_LEN-1:0] req_type,
    input  logic [XLEN-1:0]         req_addr,
    input  logic [XLEN-1:0]         req_wdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [XLEN/8-1:0]       mem_be,
    output logic [XLEN-1:0]         mem_addr,
    output logic [XLEN-1:0]         mem_wdata,
    input  logic                    mem_ack,
    input  logic [XLEN-1:0]         mem_rdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [XLEN-1:0]         rsp_data,
    output logic [XLEN-1:0]         rsp_addr,
    output logic [MEM_TYPE_LEN-1:0] rsp_type,
    output logic                    rsp_misaligned,
    output logic                    rsp_timeout,
    output logic                    busy
);

    localparam int NB    = XLEN / 8;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    req_ready_reg;
    logic                    busy_reg;
    logic                    mem_en_reg;
    logic                    mem_we_reg;
    logic [NB-1:0]           mem_be_reg;
    logic [XLEN-1:0]         mem_addr_reg;
    logic [XLEN-1:0]         mem_wdata_reg;
    logic                    rsp_valid_reg;
    logic [XLEN-1:0]         rsp_data_reg;
    logic [XLEN-1:0]         rsp_addr_reg;
    logic [MEM_TYPE_LEN-1:0] rsp_type_reg;
    logic                    rsp_misaligned_reg;
    logic                    rsp_timeout_reg;

    // Request decode: only feeds registers, never an output directly.
    logic [1:0]      req_off;
    logic [2:0]      req_size;
    logic            req_misaligned;
    logic [NB-1:0]   req_be;
    logic [XLEN-1:0] req_wdata_sh;

    assign req_off = req_addr[1:0];

    // Unknown codes fall through to word size.
    always_comb begin
        req_size = 3'd4;
        if (req_type == MEM_B || req_type == MEM_BU) begin
            req_size = 3'd1;
        end else if (req_type == MEM_H || req_type == MEM_HU) begin
            req_size = 3'd2;
        end
    end

    assign req_misaligned = ((req_size == 3'd2) && req_addr[0]) ||
                            ((req_size == 3'd4) && (req_off != 2'b00));

    // A lane is enabled when it lies inside [off, off+size).
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_be
            assign req_be[gi] = (4'(gi) >= {2'b00, req_off}) &&
                                (4'(gi) < ({2'b00, req_off} + {1'b0, req_size}));
        end
    endgenerate

    assign req_wdata_sh = req_wdata << {req_off, 3'b000};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= IDLE;
            cnt_reg            <= '0;
            req_ready_reg      <= 1'b1;
            busy_reg           <= 1'b0;
            mem_en_reg         <= 1'b0;
            mem_we_reg         <= 1'b0;
            mem_be_reg         <= '0;
            mem_addr_reg       <= '0;
            mem_wdata_reg      <= '0;
            rsp_valid_reg      <= 1'b0;
            rsp_data_reg       <= '0;
            rsp_addr_reg       <= '0;
            rsp_type_reg       <= '0;
            rsp_misaligned_reg <= 1'b0;
            rsp_timeout_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        req_ready_reg      <= 1'b0;
                        busy_reg           <= 1'b1;
                        cnt_reg            <= '0;
                        rsp_addr_reg       <= req_addr;
                        rsp_type_reg       <= req_type;
                        rsp_data_reg       <= '0;
                        rsp_timeout_reg    <= 1'b0;
                        rsp_misaligned_reg <= req_misaligned;
                        if (req_misaligned) begin
                            state_reg     <= RESP;
                            rsp_valid_reg <= 1'b1;
                        end else begin
                            state_reg     <= ACCESS;
                            mem_en_reg    <= 1'b1;
                            mem_we_reg    <= req_we;
                            mem_be_reg    <= req_be;
                            mem_addr_reg  <= {req_addr[XLEN-1:2], 2'b00};
                            mem_wdata_reg <= req_wdata_sh;
                        end
                    end
                end
                ACCESS: begin
                    // Ack takes priority over an expiring timeout.
                    if (mem_ack) begin
                        state_reg     <= RESP;
                        mem_en_reg    <= 1'b0;
                        mem_we_reg    <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_data_reg  <= mem_we_reg ? '0 : mem_rdata;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg       <= RESP;
                        mem_en_reg      <= 1'b0;
                        mem_we_reg      <= 1'b0;
                        rsp_valid_reg   <= 1'b1;
                        rsp_timeout_reg <= 1'b1;
                        rsp_data_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    mem_en_reg    <= 1'b0;
                    mem_we_reg    <= 1'b0;
                    rsp_valid_reg <= 1'b0;
                    req_ready_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready      = req_ready_reg;
    assign busy           = busy_reg;
    assign mem_en         = mem_en_reg;
    assign mem_we         = mem_we_reg;
    assign mem_be         = mem_be_reg;
    assign mem_addr       = mem_addr_reg;
    assign mem_wdata      = mem_wdata_reg;
    assign rsp_valid      = rsp_valid_reg;
    assign rsp_data       = rsp_data_reg;
    assign rsp_addr       = rsp_addr_reg;
    assign rsp_type       = rsp_type_reg;
    assign rsp_misaligned = rsp_misaligned_reg;
    assign rsp_timeout    = rsp_timeout_reg;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: transaction-level expectations drive a
// per-cycle compare process; directed cases pin literal values.
module tb_mem_access;

    localparam int T = 4;
    localparam logic [2:0] TB_B = 3'd0, TB_H = 3'd1, TB_W = 3'd2, TB_BU = 3'd4, TB_HU = 3'd5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_type = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rsp_valid, req_ready, busy;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data, rsp_addr;
    logic [2:0]  rsp_type;
    logic        rsp_misaligned, rsp_timeout;

    always #5 clk = ~clk;

    mem_access #(.XLEN(32), .MEM_TYPE_LEN(3), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_addr(rsp_addr), .rsp_type(rsp_type), .rsp_misaligned(rsp_misaligned),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp_v, $time);
        end
    endtask

    // Expected-behaviour state, updated by the driver each cycle.
    logic        chk_on = 1'b0;
    logic        e_busy = 1'b0, mem_ok = 1'b0, rsp_ok = 1'b0;
    logic        e_we, e_mis, e_to;
    logic [3:0]  e_be;
    logic [31:0] e_maddr, e_wdata, e_raddr, e_rdata;
    logic [2:0]  e_rtype;
    int          cur_cyc = 0;

    // Observations for the directed literal checks.
    int          obs_en_cnt, obs_rsp_cyc;
    logic        obs_rsp_seen, obs_we;
    logic [3:0]  obs_be;
    logic [31:0] obs_addr, obs_wdata, obs_rdata, obs_raddr;
    logic [2:0]  obs_rtype;
    logic        obs_mis, obs_to;

    always @(negedge clk) begin
        if (chk_on && !reset) begin
            chk("busy", {31'b0, busy}, {31'b0, e_busy});
            chk("req_ready", {31'b0, req_ready}, {31'b0, !e_busy});
            chk("mem_en", {31'b0, mem_en}, {31'b0, mem_ok});
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, rsp_ok});
            if (mem_en && mem_ok) begin
                chk("mem_addr", mem_addr, e_maddr);
                chk("mem_be", {28'b0, mem_be}, {28'b0, e_be});
                chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
                if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
                obs_en_cnt++;
                obs_be = mem_be; obs_addr = mem_addr; obs_wdata = mem_wdata; obs_we = mem_we;
            end
            if (rsp_valid && rsp_ok) begin
                chk("rsp_data", rsp_data, e_rdata);
                chk("rsp_addr", rsp_addr, e_raddr);
                chk("rsp_type", {29'b0, rsp_type}, {29'b0, e_rtype});
                chk("rsp_mis", {31'b0, rsp_misaligned}, {31'b0, e_mis});
                chk("rsp_to", {31'b0, rsp_timeout}, {31'b0, e_to});
                if (!obs_rsp_seen) begin
                    obs_rsp_seen = 1'b1;
                    obs_rsp_cyc = cur_cyc;
                end
                obs_rdata = rsp_data; obs_raddr = rsp_addr; obs_rtype = rsp_type;
                obs_mis = rsp_misaligned; obs_to = rsp_timeout;
            end
        end
    end

    // One transaction. k = cycle (after accept) in which mem_ack is driven,
    // 0 = never; r = cycles rsp_ready is held low. Called at posedge+1.
    task automatic do_txn(input logic we, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] wd, input int k, input int r,
                          input logic [31:0] rd, input bit rd_rand);
        int sz, off, en_exp, lat;
        sz  = (t == TB_B || t == TB_BU) ? 1 : (t == TB_H || t == TB_HU) ? 2 : 4;
        off = int'(a[1:0]);
        e_mis = (sz == 2 && a[0]) || (sz == 4 && off != 0);
        e_to  = !e_mis && (k < 1 || k > T);
        for (int i = 0; i < 4; i++) begin
            e_be[i] = (i >= off) && (i < off + sz);
            e_wdata[8*i +: 8] = (i >= off) ? wd[8*(i-off) +: 8] : 8'h00;
        end
        e_maddr = {a[31:2], 2'b00};
        e_we = we; e_raddr = a; e_rtype = t; e_rdata = '0;
        en_exp = e_mis ? 0 : (e_to ? T : k);
        lat = en_exp + 1;
        obs_en_cnt = 0; obs_rsp_seen = 1'b0; obs_rsp_cyc = -1;
        req_valid = 1'b1; req_we = we; req_type = t; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom;
        req_type = 3'($urandom);
        e_busy = 1'b1;
        for (int cyc = 1; cyc <= lat + r; cyc++) begin
            cur_cyc = cyc;
            mem_ok = (cyc <= en_exp);
            rsp_ok = (cyc >= lat);
            mem_ack = (k >= 1 && cyc == k) || (cyc > lat && $urandom_range(1) == 1);
            mem_rdata = (rd_rand || !mem_ack) ? $urandom : rd;
            if (mem_ack && cyc <= en_exp && !we) e_rdata = mem_rdata;
            rsp_ready = (cyc == lat + r);
            req_valid = (cyc >= lat);  // pending request that must wait
            @(posedge clk); #1;
        end
        cur_cyc = 0;
        req_valid = 1'b0; mem_ack = 1'b0; rsp_ready = 1'b0;
        e_busy = 1'b0; mem_ok = 1'b0; rsp_ok = 1'b0;
    endtask

    logic [2:0] tcodes [8] = '{TB_B, TB_H, TB_W, TB_BU, TB_HU, 3'd3, 3'd6, 3'd7};

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_flags", {28'b0, mem_be}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk_on = 1'b1;
        @(posedge clk); #1;

        // LB at 0x1003, ack in first access cycle
        do_txn(1'b0, TB_B, 32'h0000_1003, 32'h0, 1, 0, 32'h80FF_1234, 1'b0);
        chk("lb_be", {28'b0, obs_be}, 32'h8);
        chk("lb_addr", obs_addr, 32'h0000_1000);
        chk("lb_rdata", obs_rdata, 32'h80FF_1234);
        chk("lb_raddr", obs_raddr, 32'h0000_1003);
        chk("lb_rtype", {29'b0, obs_rtype}, {29'b0, TB_B});
        chk("lb_lat", obs_rsp_cyc, 32'd2);

        // SH at 0x2002
        do_txn(1'b1, TB_H, 32'h0000_2002, 32'hDEAD_BEEF, 2, 1, 32'h1111_2222, 1'b0);
        chk("sh_we", {31'b0, obs_we}, 32'd1);
        chk("sh_be", {28'b0, obs_be}, 32'hC);
        chk("sh_wdata", obs_wdata, 32'hBEEF_0000);
        chk("sh_rdata", obs_rdata, 32'd0);

        // Misaligned LW at 0x3001
        do_txn(1'b0, TB_W, 32'h0000_3001, 32'h0, 1, 0, 32'h5, 1'b0);
        chk("mis_en_cnt", obs_en_cnt, 32'd0);
        chk("mis_flag", {31'b0, obs_mis}, 32'd1);
        chk("mis_lat", obs_rsp_cyc, 32'd1);

        // Timeout with a late ack in the response cycle
        do_txn(1'b0, TB_W, 32'h0000_4000, 32'h0, T + 1, 0, 32'hAAAA_5555, 1'b0);
        chk("to_en_cnt", obs_en_cnt, T);
        chk("to_flag", {31'b0, obs_to}, 32'd1);
        chk("to_rdata", obs_rdata, 32'd0);
        chk("to_lat", obs_rsp_cyc, T + 1);

        // Ack in the same cycle the timeout would fire
        do_txn(1'b0, TB_HU, 32'h0000_5006, 32'h0, T, 0, 32'h1234_5678, 1'b0);
        chk("edge_to", {31'b0, obs_to}, 32'd0);
        chk("edge_rdata", obs_rdata, 32'h1234_5678);
        chk("edge_en_cnt", obs_en_cnt, T);

        // Backpressure for 5 cycles
        do_txn(1'b0, TB_BU, 32'h0000_6001, 32'h0, 3, 5, 32'hCAFE_F00D, 1'b0);
        chk("bp_lat", obs_rsp_cyc, 32'd4);
        chk("bp_rdata", obs_rdata, 32'hCAFE_F00D);

        // Reset in the middle of ACCESS
        chk_on = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_type = TB_W; req_addr = 32'h0000_7000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rstmid_busy", {31'b0, busy}, 32'd0);
        chk("rstmid_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rstmid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            mem_ack = (i == 0);
            @(negedge clk);
            chk("rstmid_no_rsp", {31'b0, rsp_valid}, 32'd0);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk_on = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            do_txn(1'($urandom_range(1)), tcodes[$urandom_range(7)], $urandom, $urandom,
                   int'($urandom_range(0, T + 2)), int'($urandom_range(0, 3)), 32'h0, 1'b1);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Load/store access controller sitting between the execute stage and the data-memory port, directly upstream of `mem_load`. It takes one load or store request at a time, checks alignment, builds the word-aligned address, byte enables and lane-shifted store data, runs a req/ack handshake with memory (with a timeout), and returns the raw memory word with the original byte address and load type. `mem_load` then does the sign/zero extension.

## Interface

Parameters:
- `XLEN`, 32: data and address width. Byte-lane logic is defined for 32 only.
- `MEM_TYPE_LEN`, from `constants.vh`: width of the access-type code.
  - Codes `MEM_B`, `MEM_H`, `MEM_W`, `MEM_BU`, `MEM_HU` come from `constants.vh`.
- `TIMEOUT_CYCLES`, 255: maximum number of ACCESS cycles to wait for `mem_ack`. Must be ≥ 1.

Clocking and reset:
- One clock.
- Reset is synchronous and active-high.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  execute stage presents a request.
- `req_ready`  out  1  block can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_type`  in  `MEM_TYPE_LEN`  access size/sign code.
- `req_addr`  in  `XLEN`  byte address.
- `req_wdata`  in  `XLEN`  store data, right-justified.
- `mem_en`  out  1  memory request strobe.
- `mem_we`  out  1  memory write.
- `mem_be`  out  `XLEN/8`  byte enables.
- `mem_addr`  out  `XLEN`  word-aligned address; bits [1:0] are 0.
- `mem_wdata`  out  `XLEN`  lane-shifted store data.
- `mem_ack`  in  1  memory completes the access this cycle.
- `mem_rdata`  in  `XLEN`  read word; valid when `mem_ack`=1.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  writeback consumes the response.
- `rsp_data`  out  `XLEN`  raw word for `mem_load`; 0 for stores and faults.
- `rsp_addr`  out  `XLEN`  original byte address.
- `rsp_type`  out  `MEM_TYPE_LEN`  original type.
- `rsp_misaligned`  out  1  alignment fault.
- `rsp_timeout`  out  1  no ack within `TIMEOUT_CYCLES`.
- `busy`  out  1  state ≠ IDLE.

## Operation

FSM states are IDLE, ACCESS, RESP.

- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch `req_we`, `req_type`, `req_addr`, `req_wdata`.
  - If the access is misaligned, go to RESP with `rsp_misaligned`=1 and issue no memory access. Otherwise go to ACCESS.
- **Misalignment rules**
  - H/HU is misaligned when addr[0]=1.
  - W is misaligned when addr[1:0]≠0.
  - B/BU is never misaligned.
  - Unknown type codes are treated as W.
- **ACCESS**
  - `mem_en`=1. `mem_we`, `mem_be`, `mem_addr` and `mem_wdata` are held stable from the latched request.
  - Byte enables, with off = addr[1:0]:
    - B/BU: 4'b0001<<off.
    - H/HU: 4'b0011<<off.
    - W: 4'b1111.
  - Store data: `mem_wdata` = wdata << {off,3'b0}.
  - Read byte enables equal write byte enables.
  - On `mem_ack`: capture `mem_rdata` for loads (0 for stores) and go to RESP.
  - A timeout counter clears on entry and increments each ACCESS cycle without ack. When it reaches `TIMEOUT_CYCLES`, go to RESP with `rsp_timeout`=1 and `rsp_data`=0.
  - If ack and timeout fall in the same cycle, the ack wins.
- **RESP**
  - `rsp_valid`=1. All `rsp_*` outputs are held stable until `rsp_ready`=1.
  - Then go to IDLE. No new request is accepted in that same cycle.
- **Ack outside ACCESS**
  - `mem_ack` in IDLE or RESP (e.g. a late ack after timeout) is ignored.
- **Reset**
  - State goes to IDLE.
  - `req_ready`=1.
  - `mem_en`, `mem_we`, `rsp_valid`, `rsp_misaligned`, `rsp_timeout`, `busy`=0.
  - `mem_be`, `mem_addr`, `mem_wdata`, `rsp_data`, `rsp_addr`, `rsp_type`=0.
  - Counter=0.
- **Reset mid-operation**
  - Any in-flight access is abandoned. `mem_en` is low from the cycle after reset is sampled, and no response is produced.

## Timing

- All outputs are registered or decoded purely from state plus latched registers. There is no combinational path from `req_*` to `mem_*`.
- Request accepted at cycle N → `mem_en` high at N+1.
- Ack at cycle N+k (k≥1) → `rsp_valid` at N+k+1.
- Minimum load-to-response latency is 2 cycles.
- Misaligned request at N → `rsp_valid` at N+1. `mem_en` never asserts.
- Timeout: `mem_en` is high for exactly `TIMEOUT_CYCLES` cycles, then `rsp_valid` asserts on the next cycle.
- Throughput: at most one request per 3 cycles, because IDLE must be revisited after each response.

## Test plan

- **LB at 0x1003.** `mem_rdata`=0x80FF_1234, ack after 1 cycle → `mem_be`=4'b1000, `mem_addr`=0x1000, `rsp_data`=0x80FF1234, `rsp_addr`=0x1003, `rsp_type`=MEM_B. Response 2 cycles after accept.
- **SH at 0x2002.** `req_wdata`=0xDEAD_BEEF → `mem_we`=1, `mem_be`=4'b1100, `mem_wdata`=0xBEEF_0000, `rsp_data`=0.
- **Misaligned LW at 0x3001.** → `mem_en` never asserts. `rsp_valid`=1 one cycle after accept with `rsp_misaligned`=1.
- **Timeout.** `TIMEOUT_CYCLES`=4, no ack → `mem_en` high for exactly 4 cycles, then `rsp_timeout`=1. A late ack the following cycle changes nothing.
- **Backpressure.** `rsp_ready` held low 5 cycles → `rsp_*` stable throughout, `req_ready`=0, and a pending `req_valid` is accepted only after return to IDLE.
- **Reset mid-ACCESS.** `reset` asserted during ACCESS → next cycle `mem_en`=0, `busy`=0, `req_ready`=1, no `rsp_valid`.
